data_memory_master: RTL and testbench
=====================================

Name: data_memory_master

Overview:
Initiator side of the data-memory interface. It accepts single or burst load/store requests from the datapath over a valid/ready handshake and drives the memory strobes MemoryRead/MemoryWrite, the address and the write data. It captures read data after a fixed latency and returns it as a data stream. It sits between the pipeline's memory stage and the DataMemory array and owns all strobe timing toward it.

Parameters:
ADDR_WIDTH, 8, word-address bits used; memory depth is 2^ADDR_WIDTH words; MemAddress upper bits are driven 0.
DATA_WIDTH, 32, word width.
LEN_WIDTH, 4, width of ReqLength; a burst is ReqLength+1 words (1..16).
READ_LATENCY, 2, cycles from the MemoryRead cycle to the RdValid cycle; must be >= 2.

Ports:
Clock  in  1  system clock; all state updates on the rising edge.
Reset  in  1  synchronous, active-high reset.
ReqValid  in  1  request present.
ReqReady  out  1  high only in IDLE.
ReqWrite  in  1  1 = store burst, 0 = load burst.
ReqAddress  in  ADDR_WIDTH  first word address.
ReqLength  in  LEN_WIDTH  burst word count minus 1.
WrValid  in  1  store data word present.
WrReady  out  1  high only in WR_DATA.
WrData  in  DATA_WIDTH  store data.
RdValid  out  1  one-cycle pulse per loaded word; no backpressure.
RdData  out  DATA_WIDTH  loaded word; valid while RdValid is high.
Done  out  1  one-cycle pulse when a burst completes.
MemAddress  out  32  to memory Address.
MemWriteData  out  DATA_WIDTH  to memory WriteData.
MemoryRead  out  1  to memory read strobe.
MemoryWrite  out  1  to memory write strobe.
MemReadData  in  DATA_WIDTH  from memory ReadData.

Behaviour:
- All outputs are registered except ReqReady and WrReady, which decode the current state.
- Reset values:
  - state = IDLE, so ReqReady = 1.
  - MemoryRead, MemoryWrite, RdValid, Done, WrReady = 0.
  - MemAddress, MemWriteData, RdData = 0.
  - Burst counter and wait counter = 0.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_DATA, WR_ISSUE.
- Acceptance (IDLE with ReqValid): latch address, length and direction.
  - ReqWrite = 1 goes to WR_DATA; ReqWrite = 0 goes to RD_ISSUE.
  - Request inputs are sampled only at acceptance. ReqValid outside IDLE is ignored.
- RD_ISSUE (exactly 1 cycle): MemoryRead = 1, MemAddress = current address, then go to RD_WAIT.
- RD_WAIT: stays READ_LATENCY-1 cycles.
  - On its last edge it captures MemReadData into RdData and pulses RdValid in the following cycle.
  - If words remain, increment the address and go to RD_ISSUE, so the next MemoryRead coincides with the previous RdValid. Otherwise go to IDLE.
  - Load throughput is one word per READ_LATENCY cycles.
- WR_DATA: WrReady = 1.
  - On WrValid: latch WrData into MemWriteData, drive MemAddress, go to WR_ISSUE.
  - Waits indefinitely for WrValid. WrValid outside WR_DATA is ignored.
- WR_ISSUE (exactly 1 cycle): MemoryWrite = 1 with MemAddress and MemWriteData stable for the whole cycle, because the memory writes on the falling edge inside this cycle.
  - If words remain, increment the address and go to WR_DATA. Otherwise go to IDLE.
- Done: high in the first IDLE cycle after the last word.
  - For loads, this is the same cycle as the last RdValid.
  - A new request may be accepted in the Done cycle.
- MemoryRead and MemoryWrite are never high together. Both are 0 in IDLE, RD_WAIT and WR_DATA.
- MemAddress holds its last value when not strobing.
- Address increment wraps modulo 2^ADDR_WIDTH (0xFF -> 0x00 at the default).
- Burst counter counts down from ReqLength; the burst ends when it reaches 0 after a word completes.
- Reset mid-burst: abort at that edge with no further strobes, RdValid or Done, and return to IDLE.
  - If Reset is sampled at the end of a WR_ISSUE cycle, that write has already occurred and is not undone.
  - A read in flight is discarded.

Test Plan:
- Reset, then store ReqAddress=0x05 ReqLength=0 WrData=0xDEADBEEF -> one MemoryWrite cycle at MemAddress=5; Done the next cycle. Then a load at 0x05 -> RdValid with RdData=0xDEADBEEF exactly 2 cycles after the MemoryRead cycle, Done in the same cycle.
- Store burst at 0x10, ReqLength=3, data 1,2,3,4 with WrValid gapped by 2 idle cycles -> exactly 4 MemoryWrite pulses at 0x10..0x13, each after its WrValid. Load burst back -> 1,2,3,4 in order with RdValid every 2 cycles, Done with the 4th word.
- Load burst from 0xFE, ReqLength=2 -> MemAddress sequence 0xFE, 0xFF, 0x00; 3 RdValid pulses.
- ReqValid held high during a burst -> ReqReady=0 and no new acceptance until the Done cycle. Request presented in the Done cycle -> accepted, MemoryRead in the next cycle.
- Reset asserted in the cycle after the 2nd RdValid of a 4-word load -> no further MemoryRead, RdValid or Done; ReqReady=1 on the next cycle; all outputs at reset values.
- READ_LATENCY=3 instance, 2-word load -> RdValid 3 cycles after each MemoryRead, MemoryRead pulses 3 cycles apart.

Source files
------------

// File: rtl/data_memory_master_if.sv
// Bundle of signals between the datapath, the data-memory initiator and the
// DataMemory array. The master modport is the initiator's view; the slave
// modport is the combined view of the request source and the memory.
interface data_memory_master_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 4
);
    // Request channel
    logic                  ReqValid;
    logic                  ReqReady;
    logic                  ReqWrite;
    logic [ADDR_WIDTH-1:0] ReqAddress;
    logic [LEN_WIDTH-1:0]  ReqLength;

    // Store data stream
    logic                  WrValid;
    logic                  WrReady;
    logic [DATA_WIDTH-1:0] WrData;

    // Load data stream and completion
    logic                  RdValid;
    logic [DATA_WIDTH-1:0] RdData;
    logic                  Done;

    // Memory side
    logic [31:0]           MemAddress;
    logic [DATA_WIDTH-1:0] MemWriteData;
    logic                  MemoryRead;
    logic                  MemoryWrite;
    logic [DATA_WIDTH-1:0] MemReadData;

    modport master (
        input  ReqValid,
        input  ReqWrite,
        input  ReqAddress,
        input  ReqLength,
        input  WrValid,
        input  WrData,
        input  MemReadData,
        output ReqReady,
        output WrReady,
        output RdValid,
        output RdData,
        output Done,
        output MemAddress,
        output MemWriteData,
        output MemoryRead,
        output MemoryWrite
    );

    modport slave (
        output ReqValid,
        output ReqWrite,
        output ReqAddress,
        output ReqLength,
        output WrValid,
        output WrData,
        output MemReadData,
        input  ReqReady,
        input  WrReady,
        input  RdValid,
        input  RdData,
        input  Done,
        input  MemAddress,
        input  MemWriteData,
        input  MemoryRead,
        input  MemoryWrite
    );
endinterface

// File: rtl/data_memory_master.sv
// Initiator for the data-memory array. Accepts single/burst load and store
// requests, owns the MemoryRead/MemoryWrite strobe timing, captures read data
// after a fixed latency and returns it as a pulse stream.
module data_memory_master #(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned LEN_WIDTH    = 4,
    parameter int unsigned READ_LATENCY = 2
) (
    input logic                     Clock,
    input logic                     Reset,
    data_memory_master_if.master    bus
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StRdIssue = 3'd1;
    localparam logic [2:0] StRdWait  = 3'd2;
    localparam logic [2:0] StWrData  = 3'd3;
    localparam logic [2:0] StWrIssue = 3'd4;

    // RD_WAIT lasts READ_LATENCY-1 cycles; the counter runs from
    // READ_LATENCY-2 down to 0, and 0 marks the capture cycle.
    localparam int unsigned WAIT_WIDTH = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
    localparam logic [WAIT_WIDTH-1:0] WAIT_INIT = WAIT_WIDTH'(READ_LATENCY - 2);

    logic [2:0]            stateQ, stateD;
    logic [ADDR_WIDTH-1:0] addrQ, addrD;
    logic [LEN_WIDTH-1:0]  burstQ, burstD;
    logic [WAIT_WIDTH-1:0] waitQ, waitD;

    logic                  memReadQ, memReadD;
    logic                  memWriteQ, memWriteD;
    logic [31:0]           memAddrQ, memAddrD;
    logic [DATA_WIDTH-1:0] memWdataQ, memWdataD;
    logic                  rdValidQ, rdValidD;
    logic [DATA_WIDTH-1:0] rdDataQ, rdDataD;
    logic                  doneQ, doneD;

    // Word address of the next word; wraps modulo the memory depth.
    logic [ADDR_WIDTH-1:0] addrInc;
    assign addrInc = addrQ + ADDR_WIDTH'(1);

    // Next-state, counters and registered-output decode.
    always_comb begin
        stateD    = stateQ;
        addrD     = addrQ;
        burstD    = burstQ;
        waitD     = waitQ;
        memReadD  = 1'b0;
        memWriteD = 1'b0;
        memAddrD  = memAddrQ;
        memWdataD = memWdataQ;
        rdValidD  = 1'b0;
        rdDataD   = rdDataQ;
        doneD     = 1'b0;

        case (stateQ)
            StIdle: begin
                if (bus.ReqValid) begin
                    addrD    = bus.ReqAddress;
                    burstD   = bus.ReqLength;
                    memAddrD = 32'(bus.ReqAddress);
                    if (bus.ReqWrite) begin
                        stateD = StWrData;
                    end else begin
                        stateD   = StRdIssue;
                        memReadD = 1'b1;
                    end
                end
            end

            StRdIssue: begin
                stateD = StRdWait;
                waitD  = WAIT_INIT;
            end

            StRdWait: begin
                if (waitQ != '0) begin
                    waitD = waitQ - WAIT_WIDTH'(1);
                end else begin
                    rdDataD  = bus.MemReadData;
                    rdValidD = 1'b1;
                    if (burstQ == '0) begin
                        stateD = StIdle;
                        doneD  = 1'b1;
                    end else begin
                        // Next strobe overlaps the RdValid of this word.
                        burstD   = burstQ - LEN_WIDTH'(1);
                        addrD    = addrInc;
                        memAddrD = 32'(addrInc);
                        memReadD = 1'b1;
                        stateD   = StRdIssue;
                    end
                end
            end

            StWrData: begin
                if (bus.WrValid) begin
                    memWdataD = bus.WrData;
                    memAddrD  = 32'(addrQ);
                    memWriteD = 1'b1;
                    stateD    = StWrIssue;
                end
            end

            StWrIssue: begin
                if (burstQ == '0) begin
                    stateD = StIdle;
                    doneD  = 1'b1;
                end else begin
                    // MemAddress is only updated once the next data word arrives.
                    burstD = burstQ - LEN_WIDTH'(1);
                    addrD  = addrInc;
                    stateD = StWrData;
                end
            end

            default: begin
                stateD = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            stateQ    <= StIdle;
            addrQ     <= '0;
            burstQ    <= '0;
            waitQ     <= '0;
            memReadQ  <= 1'b0;
            memWriteQ <= 1'b0;
            memAddrQ  <= '0;
            memWdataQ <= '0;
            rdValidQ  <= 1'b0;
            rdDataQ   <= '0;
            doneQ     <= 1'b0;
        end else begin
            stateQ    <= stateD;
            addrQ     <= addrD;
            burstQ    <= burstD;
            waitQ     <= waitD;
            memReadQ  <= memReadD;
            memWriteQ <= memWriteD;
            memAddrQ  <= memAddrD;
            memWdataQ <= memWdataD;
            rdValidQ  <= rdValidD;
            rdDataQ   <= rdDataD;
            doneQ     <= doneD;
        end
    end

    assign bus.ReqReady     = (stateQ == StIdle);
    assign bus.WrReady      = (stateQ == StWrData);
    assign bus.MemoryRead   = memReadQ;
    assign bus.MemoryWrite  = memWriteQ;
    assign bus.MemAddress   = memAddrQ;
    assign bus.MemWriteData = memWdataQ;
    assign bus.RdValid      = rdValidQ;
    assign bus.RdData       = rdDataQ;
    assign bus.Done         = doneQ;

endmodule

// File: tb/tb_data_memory_master.sv
// Bench for data_memory_master: a latency-2 and a latency-3 instance, each on
// its own memory model. Expected strobe/response/done cycles come from the
// burst timing rules and a reference copy of the memory contents.
module tb_data_memory_master;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    data_memory_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LEN_WIDTH(4)) busA ();
    data_memory_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LEN_WIDTH(4)) busB ();

    data_memory_master #(
        .ADDR_WIDTH(8), .DATA_WIDTH(32), .LEN_WIDTH(4), .READ_LATENCY(2)
    ) dutA (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (busA)
    );

    data_memory_master #(
        .ADDR_WIDTH(8), .DATA_WIDTH(32), .LEN_WIDTH(4), .READ_LATENCY(3)
    ) dutB (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (busB)
    );

    // Memory models: write on the falling edge, registered read data.
    logic [31:0] memA [256];
    logic [31:0] memB [256];
    logic [31:0] refMem [256];
    logic [31:0] rdPipeA = 32'h0;
    logic [31:0] rdPipeB = 32'h0;

    always @(negedge Clock) begin
        if (busA.MemoryWrite) memA[busA.MemAddress[7:0]] = busA.MemWriteData;
        if (busB.MemoryWrite) memB[busB.MemAddress[7:0]] = busB.MemWriteData;
    end
    always @(posedge Clock) begin
        if (busA.MemoryRead) rdPipeA <= memA[busA.MemAddress[7:0]];
        if (busB.MemoryRead) rdPipeB <= memB[busB.MemAddress[7:0]];
    end
    assign busA.MemReadData = rdPipeA;
    assign busB.MemReadData = rdPipeB;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // Event logs: {cycle, address, data}.
    logic [95:0] gotIss[$], gotRdv[$], gotWr[$], gotDone[$];
    logic [95:0] expIss[$], expRdv[$], expWr[$], expDone[$];
    int overlap = 0;

    always @(negedge Clock) begin
        if (busA.MemoryRead)  gotIss.push_back({32'(cyc), busA.MemAddress, 32'h0});
        if (busA.RdValid)     gotRdv.push_back({32'(cyc), 32'h0, busA.RdData});
        if (busA.MemoryWrite) gotWr.push_back({32'(cyc), busA.MemAddress, busA.MemWriteData});
        if (busA.Done)        gotDone.push_back({32'(cyc), 64'h0});
        if (busB.MemoryRead)  gotIss.push_back({32'(cyc), busB.MemAddress, 32'h0});
        if (busB.RdValid)     gotRdv.push_back({32'(cyc), 32'h0, busB.RdData});
        if (busB.MemoryWrite) gotWr.push_back({32'(cyc), busB.MemAddress, busB.MemWriteData});
        if (busB.Done)        gotDone.push_back({32'(cyc), 64'h0});
        if (busA.MemoryRead && busA.MemoryWrite) overlap++;
        if (busB.MemoryRead && busB.MemoryWrite) overlap++;
    end

    int nChecks = 0;
    int nFail = 0;
    logic [31:0] stData[$];

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        nChecks++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [31:0] initWord(input int i);
        return 32'(i) * 32'h9E3779B1 + 32'h1234;
    endfunction

    // Expected events of a load burst accepted at edge a0.
    task automatic expectLoad(input int a0, input int addr, input int len, input int lat);
        int a;
        for (int i = 0; i <= len; i++) begin
            a = (addr + i) % 256;
            expIss.push_back({32'(a0 + i * lat), 32'(a), 32'h0});
            expRdv.push_back({32'(a0 + (i + 1) * lat), 32'h0, refMem[a]});
        end
        expDone.push_back({32'(a0 + (len + 1) * lat), 64'h0});
    endtask

    task automatic checkLogs(input string tag);
        check({tag, " read-strobe count"}, 96'(gotIss.size()), 96'(expIss.size()));
        for (int i = 0; i < gotIss.size() && i < expIss.size(); i++)
            check($sformatf("%s read-strobe[%0d]", tag, i), gotIss[i], expIss[i]);
        check({tag, " rdvalid count"}, 96'(gotRdv.size()), 96'(expRdv.size()));
        for (int i = 0; i < gotRdv.size() && i < expRdv.size(); i++)
            check($sformatf("%s rdvalid[%0d]", tag, i), gotRdv[i], expRdv[i]);
        check({tag, " write-strobe count"}, 96'(gotWr.size()), 96'(expWr.size()));
        for (int i = 0; i < gotWr.size() && i < expWr.size(); i++)
            check($sformatf("%s write-strobe[%0d]", tag, i), gotWr[i], expWr[i]);
        check({tag, " done count"}, 96'(gotDone.size()), 96'(expDone.size()));
        for (int i = 0; i < gotDone.size() && i < expDone.size(); i++)
            check($sformatf("%s done[%0d]", tag, i), gotDone[i], expDone[i]);
        gotIss.delete(); gotRdv.delete(); gotWr.delete(); gotDone.delete();
        expIss.delete(); expRdv.delete(); expWr.delete(); expDone.delete();
    endtask

    task automatic checkResetState(input string tag);
        check({tag, " ReqReady"},     96'(busA.ReqReady),     96'(1));
        check({tag, " WrReady"},      96'(busA.WrReady),      96'(0));
        check({tag, " MemoryRead"},   96'(busA.MemoryRead),   96'(0));
        check({tag, " MemoryWrite"},  96'(busA.MemoryWrite),  96'(0));
        check({tag, " RdValid"},      96'(busA.RdValid),      96'(0));
        check({tag, " Done"},         96'(busA.Done),         96'(0));
        check({tag, " MemAddress"},   96'(busA.MemAddress),   96'(0));
        check({tag, " MemWriteData"}, 96'(busA.MemWriteData), 96'(0));
        check({tag, " RdData"},       96'(busA.RdData),       96'(0));
    endtask

    task automatic doLoad(input int addr, input int len, input string tag);
        int a0;
        check({tag, " ReqReady"}, 96'(busA.ReqReady), 96'(1));
        busA.ReqValid   = 1'b1;
        busA.ReqWrite   = 1'b0;
        busA.ReqAddress = 8'(addr);
        busA.ReqLength  = 4'(len);
        tick();
        a0 = cyc;
        busA.ReqValid = 1'b0;
        expectLoad(a0, addr, len, 2);
        while (cyc < a0 + (len + 1) * 2 + 2) tick();
        checkLogs(tag);
    endtask

    // Store burst; data words come from stData, each after gap idle cycles.
    task automatic doStore(input int addr, input int len, input int gap, input string tag);
        int e;
        int a;
        e = cyc;
        check({tag, " ReqReady"}, 96'(busA.ReqReady), 96'(1));
        busA.ReqValid   = 1'b1;
        busA.ReqWrite   = 1'b1;
        busA.ReqAddress = 8'(addr);
        busA.ReqLength  = 4'(len);
        tick();
        busA.ReqValid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            a = (addr + i) % 256;
            repeat (gap) tick();
            busA.WrValid = 1'b1;
            busA.WrData  = stData[i];
            for (int k = 0; k < 20 && !busA.WrReady; k++) tick();
            check($sformatf("%s WrReady[%0d]", tag, i), 96'(busA.WrReady), 96'(1));
            tick();
            e = cyc;
            busA.WrValid = 1'b0;
            expWr.push_back({32'(e), 32'(a), stData[i]});
            refMem[a] = stData[i];
        end
        expDone.push_back({32'(e + 1), 64'h0});
        while (cyc < e + 3) tick();
        checkLogs(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int a0;
        int b0;
        for (int i = 0; i < 256; i++) begin
            memA[i]   = initWord(i);
            memB[i]   = initWord(i);
            refMem[i] = initWord(i);
        end
        Reset = 1'b1;
        busA.ReqValid = 1'b0; busA.ReqWrite = 1'b0; busA.ReqAddress = '0; busA.ReqLength = '0;
        busA.WrValid = 1'b0; busA.WrData = '0;
        busB.ReqValid = 1'b0; busB.ReqWrite = 1'b0; busB.ReqAddress = '0; busB.ReqLength = '0;
        busB.WrValid = 1'b0; busB.WrData = '0;
        repeat (3) tick();
        checkResetState("reset");
        Reset = 1'b0;
        tick();

        // Single store then load back.
        stData = '{32'hDEADBEEF};
        doStore(8'h05, 0, 0, "store single");
        doLoad(8'h05, 0, "load single");

        // Four-word store with gapped data, then load back.
        stData = '{32'd1, 32'd2, 32'd3, 32'd4};
        doStore(8'h10, 3, 2, "store burst");
        doLoad(8'h10, 3, "load burst");

        // Address wrap.
        doLoad(8'hFE, 2, "load wrap");

        // Request held during a burst; re-presented in the Done cycle.
        busA.ReqValid   = 1'b1;
        busA.ReqWrite   = 1'b0;
        busA.ReqAddress = 8'h20;
        busA.ReqLength  = 4'd1;
        tick();
        a0 = cyc;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("held ReqReady[%0d]", k), 96'(busA.ReqReady), 96'(0));
            tick();
        end
        check("held Done", 96'(busA.Done), 96'(1));
        check("held ReqReady in Done", 96'(busA.ReqReady), 96'(1));
        busA.ReqAddress = 8'h30;
        busA.ReqLength  = 4'd0;
        tick();
        b0 = cyc;
        busA.ReqValid = 1'b0;
        expectLoad(a0, 8'h20, 1, 2);
        expectLoad(b0, 8'h30, 0, 2);
        while (cyc < b0 + 4) tick();
        checkLogs("held request");

        // Reset in the cycle after the 2nd RdValid of a 4-word load.
        busA.ReqValid   = 1'b1;
        busA.ReqWrite   = 1'b0;
        busA.ReqAddress = 8'h40;
        busA.ReqLength  = 4'd3;
        tick();
        a0 = cyc;
        busA.ReqValid = 1'b0;
        while (cyc < a0 + 5) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checkResetState("mid-burst reset");
        for (int i = 0; i < 3; i++)
            expIss.push_back({32'(a0 + 2 * i), 32'(8'h40 + i), 32'h0});
        for (int i = 0; i < 2; i++)
            expRdv.push_back({32'(a0 + 2 * (i + 1)), 32'h0, refMem[8'h40 + i]});
        repeat (8) tick();
        checkLogs("mid-burst reset");

        // Latency-3 instance, two-word load.
        busB.ReqValid   = 1'b1;
        busB.ReqWrite   = 1'b0;
        busB.ReqAddress = 8'h50;
        busB.ReqLength  = 4'd1;
        tick();
        a0 = cyc;
        busB.ReqValid = 1'b0;
        expectLoad(a0, 8'h50, 1, 3);
        while (cyc < a0 + 8) tick();
        checkLogs("latency3 load");

        // Random mix of loads and stores.
        for (int t = 0; t < 24; t++) begin
            int addr;
            int len;
            addr = int'($urandom_range(0, 255));
            len  = int'($urandom_range(0, 5));
            if ($urandom_range(0, 1) == 1) begin
                stData.delete();
                for (int i = 0; i <= len; i++) stData.push_back($urandom);
                doStore(addr, len, int'($urandom_range(0, 2)), $sformatf("rand store %0d", t));
            end else begin
                doLoad(addr, len, $sformatf("rand load %0d", t));
            end
        end

        check("strobe overlap cycles", 96'(overlap), 96'(0));

        $display("%0d/%0d checks passed", nChecks - nFail, nChecks);
        $finish;
    end

endmodule
